// File: rtl/traffic_countdown.sv
// Per-direction BCD countdown of the traffic controller's lights, with a one-tick
// delayed copy of the lights, a pre-change warning and a sticky sync_err flag.

module traffic_countdown_lane #(
  parameter int unsigned D_RED    = 22,
  parameter int unsigned D_GREEN  = 29,
  parameter int unsigned D_YELLOW = 3,
  parameter int unsigned WARN_S   = 3
) (
  input  logic       clk1h,
  input  logic       rst_n,
  input  logic       first_q,
  input  logic [2:0] led,
  output logic [2:0] led_d,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones,
  output logic       warn,
  output logic       err
);

  localparam logic [2:0] C_RED = 3'b100;
  localparam logic [2:0] C_YEL = 3'b010;
  localparam logic [2:0] C_GRN = 3'b001;

  function automatic logic [7:0] to_bcd(input int unsigned d);
    return {4'(d / 10), 4'(d % 10)};
  endfunction

  localparam logic [7:0] RED_BCD  = to_bcd(D_RED);
  localparam logic [7:0] GRN_BCD  = to_bcd(D_GREEN);
  localparam logic [7:0] YEL_BCD  = to_bcd(D_YELLOW);
  localparam logic [7:0] WARN_BCD = to_bcd(WARN_S);

  logic [7:0] cnt_q;
  logic [7:0] cnt_nx;
  logic [7:0] cnt_dec;
  logic [7:0] dur;
  logic [2:0] led_d_nx;
  logic       bad_q;
  logic       bad_nx;
  logic       legal_code;
  logic       legal_step;
  logic       warn_nx;

  assign cnt_q = {cnt_tens, cnt_ones};
  assign cnt_dec = (cnt_ones == 4'd0) ? {cnt_tens - 4'd1, 4'd9}
                                      : {cnt_tens, cnt_ones - 4'd1};

  always_comb begin
    legal_code = 1'b1;
    dur        = 8'h00;
    case (led)
      C_RED:   dur = RED_BCD;
      C_YEL:   dur = YEL_BCD;
      C_GRN:   dur = GRN_BCD;
      default: legal_code = 1'b0;
    endcase
  end

  always_comb begin
    legal_step = 1'b0;
    case ({led_d, led})
      {C_GRN, C_YEL},
      {C_YEL, C_RED},
      {C_RED, C_GRN}: legal_step = 1'b1;
      default:        legal_step = 1'b0;
    endcase
  end

  // bad_q marks a fail-safe red forced by an illegal code: the next legal code
  // reloads unconditionally and its transition is not judged.
  always_comb begin
    led_d_nx = led_d;
    cnt_nx   = cnt_q;
    bad_nx   = bad_q;
    err      = 1'b0;
    if (!legal_code) begin
      led_d_nx = C_RED;
      cnt_nx   = 8'h00;
      bad_nx   = 1'b1;
      err      = 1'b1;
    end else if (first_q || bad_q || (led != led_d)) begin
      led_d_nx = led;
      cnt_nx   = dur;
      bad_nx   = 1'b0;
      if (!first_q && !bad_q && (!legal_step || (cnt_q > 8'h01)))
        err = 1'b1;
    end else if (cnt_q != 8'h00) begin
      cnt_nx = cnt_dec;
      if (cnt_q == 8'h01)
        err = 1'b1;
    end
  end

  // BCD ordering matches numeric ordering, so the threshold compares directly.
  assign warn_nx = (led_d_nx == C_GRN) && (cnt_nx <= WARN_BCD);

  always_ff @(posedge clk1h) begin
    if (!rst_n) begin
      led_d    <= C_RED;
      cnt_tens <= 4'd0;
      cnt_ones <= 4'd0;
      warn     <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      led_d    <= led_d_nx;
      cnt_tens <= cnt_nx[7:4];
      cnt_ones <= cnt_nx[3:0];
      warn     <= warn_nx;
      bad_q    <= bad_nx;
    end
  end

endmodule

module traffic_countdown #(
  parameter int unsigned D1_RED    = 22,
  parameter int unsigned D1_GREEN  = 29,
  parameter int unsigned D1_YELLOW = 3,
  parameter int unsigned D2_RED    = 32,
  parameter int unsigned D2_GREEN  = 19,
  parameter int unsigned D2_YELLOW = 3,
  parameter int unsigned WARN_S    = 3
) (
  input  logic       clk1h,
  input  logic       rst_n,
  input  logic [2:0] led1,
  input  logic [2:0] led2,
  output logic [2:0] led1_d,
  output logic [2:0] led2_d,
  output logic [3:0] cnt1_tens,
  output logic [3:0] cnt1_ones,
  output logic [3:0] cnt2_tens,
  output logic [3:0] cnt2_ones,
  output logic       warn1,
  output logic       warn2,
  output logic       sync_err
);

  logic first_q;
  logic err1;
  logic err2;

  traffic_countdown_lane #(
    .D_RED    (D1_RED),
    .D_GREEN  (D1_GREEN),
    .D_YELLOW (D1_YELLOW),
    .WARN_S   (WARN_S)
  ) u_dir1 (
    .clk1h    (clk1h),
    .rst_n    (rst_n),
    .first_q  (first_q),
    .led      (led1),
    .led_d    (led1_d),
    .cnt_tens (cnt1_tens),
    .cnt_ones (cnt1_ones),
    .warn     (warn1),
    .err      (err1)
  );

  traffic_countdown_lane #(
    .D_RED    (D2_RED),
    .D_GREEN  (D2_GREEN),
    .D_YELLOW (D2_YELLOW),
    .WARN_S   (WARN_S)
  ) u_dir2 (
    .clk1h    (clk1h),
    .rst_n    (rst_n),
    .first_q  (first_q),
    .led      (led2),
    .led_d    (led2_d),
    .cnt_tens (cnt2_tens),
    .cnt_ones (cnt2_ones),
    .warn     (warn2),
    .err      (err2)
  );

  always_ff @(posedge clk1h) begin
    if (!rst_n) begin
      first_q  <= 1'b1;
      sync_err <= 1'b0;
    end else begin
      first_q  <= 1'b0;
      sync_err <= sync_err | err1 | err2;
    end
  end

endmodule
